// File: rtl/alu_if.sv
// Bus-side signal bundle of the CPU adder/subtractor: shared bus operand,
// load/operation controls and the registered result.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] buswires;
    logic             ain;
    logic             sub;
    logic             gin;
    logic [WIDTH-1:0] aluout;

    // master: the CPU control/bus side; slave: the ALU itself
    modport master (
        output buswires, ain, sub, gin,
        input  aluout
    );

    modport slave (
        input  buswires, ain, sub, gin,
        output aluout
    );
endinterface

// File: rtl/alu.sv
// Two-step adder/subtractor: register A captures the first operand from the
// bus, register G captures A +/- bus and drives aluout directly.
module alu #(
    parameter int WIDTH = 16
) (
    input logic   clock,
    input logic   reset,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] g_next;

    // Uses the pre-edge A, so a same-cycle ain/gin pair computes with the old A.
    always_comb begin
        g_next = a_reg + bus.buswires;
        if (bus.sub) begin
            g_next = a_reg - bus.buswires;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg <= '0;
            g_reg <= '0;
        end else begin
            if (bus.ain) begin
                a_reg <= bus.buswires;
            end
            if (bus.gin) begin
                g_reg <= g_next;
            end
        end
    end

    assign bus.aluout = g_reg;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: a reference model pushes expected G values into a
// scoreboard queue as stimulus is driven; they are popped after each edge.
module tb_alu;
    localparam int WIDTH = 16;

    logic clock = 1'b0;
    logic reset;

    alu_if #(.WIDTH(WIDTH)) bus_if ();

    alu #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] a_m;
    logic [WIDTH-1:0] g_m;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // One clock transaction: drive at negedge, predict, then compare after posedge.
    task automatic step(input string tag, input bit ain, input bit sub, input bit gin,
                        input logic [WIDTH-1:0] bus);
        logic [WIDTH-1:0] expv;
        @(negedge clock);
        bus_if.ain      = ain;
        bus_if.sub      = sub;
        bus_if.gin      = gin;
        bus_if.buswires = bus;
        if (gin) g_m = sub ? (a_m - bus) : (a_m + bus);
        if (ain) a_m = bus;
        exp_q.push_back(g_m);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, "_empty_q"}, bus_if.aluout, ~bus_if.aluout);
        end else begin
            expv = exp_q.pop_front();
            check(tag, bus_if.aluout, expv);
        end
        $display("step %-10s ain=%0d sub=%0d gin=%0d bus=%h aluout=%h", tag, ain, sub, gin,
                 bus, bus_if.aluout);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] held;
        reset           = 1'b1;
        bus_if.ain      = 1'b0;
        bus_if.sub      = 1'b0;
        bus_if.gin      = 1'b0;
        bus_if.buswires = '0;
        a_m = '0;
        g_m = '0;
        #12;
        check("reset_out", bus_if.aluout, 16'h0000);
        @(negedge clock);
        reset = 1'b0;

        // Add: 100 + 50, then hold while bus changes
        step("add_ldA", 1, 0, 0, 16'd100);
        step("add_g", 0, 0, 1, 16'd50);
        check("add_150", bus_if.aluout, 16'd150);
        step("add_hold1", 0, 1, 0, 16'd999);
        step("add_hold2", 0, 0, 0, 16'h5555);
        check("add_held", bus_if.aluout, 16'd150);

        // Sub: 200 - 25
        step("sub_ldA", 1, 1, 0, 16'd200);
        step("sub_g", 0, 1, 1, 16'd25);
        check("sub_175", bus_if.aluout, 16'd175);
        step("sub_hold", 0, 0, 0, 16'hABCD);
        check("sub_held", bus_if.aluout, 16'd175);

        // Wrap-around in both directions and A - A
        step("wrapA0", 1, 0, 0, 16'h0000);
        step("wrap_sub", 0, 1, 1, 16'h0001);
        check("wrap_ffff", bus_if.aluout, 16'hFFFF);
        step("wrapAF", 1, 0, 0, 16'hFFFF);
        step("wrap_add", 0, 0, 1, 16'h0001);
        check("wrap_zero", bus_if.aluout, 16'h0000);
        step("aa_ldA", 1, 0, 0, 16'h1234);
        step("aa_sub", 0, 1, 1, 16'h1234);
        check("a_minus_a", bus_if.aluout, 16'h0000);

        // Simultaneous ain/gin uses old A
        step("sim_ldA", 1, 0, 0, 16'd10);
        step("sim_both", 1, 0, 1, 16'd5);
        check("sim_oldA", bus_if.aluout, 16'd15);
        step("sim_newA", 0, 0, 1, 16'd0);
        check("sim_newA5", bus_if.aluout, 16'd5);

        // Hold for 5 cycles with random bus/sub
        held = bus_if.aluout;
        for (int i = 0; i < 5; i++) begin
            step("hold_rand", 0, 1'($urandom_range(1)), 0, 16'($urandom));
        end
        check("hold_5cyc", bus_if.aluout, 16'd5);

        // Asynchronous reset mid-cycle, between A-load and G-load
        step("rst_ldA", 1, 0, 0, 16'd300);
        @(negedge clock);
        bus_if.ain = 1'b0;
        bus_if.gin = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", bus_if.aluout, 16'h0000);
        a_m = '0;
        g_m = '0;
        @(negedge clock);
        reset = 1'b0;
        step("rst_gzero", 0, 0, 1, 16'd0);
        step("rst_sub", 0, 1, 1, 16'd3);
        check("rst_0m3", bus_if.aluout, 16'hFFFD);
        step("rst_add", 0, 0, 1, 16'd7);
        check("rst_0p7", bus_if.aluout, 16'd7);

        // Random add/sub traffic against the model
        for (int i = 0; i < 8; i++) begin
            step("rand_op", 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 16'($urandom));
        end

        if (held !== 16'd5) begin
            check("hold_saved", held, 16'd5);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
